// File: rtl/sdm_ctrl_pkg.sv
// Shared constants for the sigma-delta modulator sequencing controller.
//   - FSM state encodings (exported on the state port)
//   - quantizer saturation codes and the saturation test helper
//   - restart counter width
package sdm_ctrl_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  localparam logic signed [3:0] SDM_QMAX = 4'sd7;
  localparam logic signed [3:0] SDM_QMIN = 4'sb1000;  // -8

  localparam int unsigned RCNT_W = 8;

  // True when the 4-bit signed quantizer code sits on either rail.
  function automatic logic is_sat(input logic [3:0] code);
    return ($signed(code) == SDM_QMAX) || ($signed(code) == SDM_QMIN);
  endfunction

endpackage

// File: rtl/sdm_sat_mon.sv
// Saturation monitor: counts consecutive rail codes from the modulator and
// flags the code that completes a run of SAT_LIM.
//   clk, rst      : clock, synchronous active-high reset
//   run_i         : controller is in RUN and enabled; codes are only counted then
//   clr_i         : controller leaves RUN this cycle; counter returns to 0
//   code_i        : signed sdm quantizer output
//   sat_trip_c_o  : combinational, this code is the SAT_LIM-th consecutive rail code
module sdm_sat_mon
  import sdm_ctrl_pkg::*;
#(
  parameter int unsigned SAT_LIM = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic       clr_i,
  input  logic [3:0] code_i,
  output logic       sat_trip_c_o
);

  localparam int unsigned SC_W = $clog2(SAT_LIM + 1);

  logic [SC_W-1:0] sat_cnt_q, sat_cnt_d;
  logic            sat_c;

  // Trip detection and consecutive-count update; frozen outside RUN.
  always_comb begin
    sat_c        = is_sat(code_i);
    sat_trip_c_o = run_i && sat_c && (sat_cnt_q == SC_W'(SAT_LIM - 1));
    sat_cnt_d    = sat_cnt_q;
    if (clr_i) begin
      sat_cnt_d = '0;
    end else if (run_i) begin
      sat_cnt_d = sat_c ? sat_cnt_q + SC_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule

// File: rtl/sdm_ctrl.sv
// Sequencing controller for the sigma-delta modulator: owns its reset and
// startup flush, paces samples into din once per OSR clocks through a
// one-entry holding buffer, and restarts the loop on sustained saturation.
//   clk, rst       : clock, synchronous active-high reset
//   en             : enable; low forces IDLE
//   s_valid/s_data : upstream sample, s_ready = holding buffer empty
//   sdm_rstn       : active-low modulator reset
//   sdm_din        : sample applied to the modulator
//   sdm_out        : signed modulator quantizer code
//   sample_strobe  : pulse in the cycle sdm_din takes a new sample
//   underrun       : pulse when a sample slot finds the buffer empty
//   restart_cnt    : saturation restarts, sticks at 255
//   state          : IDLE/FLUSH/RUN/RECOVER
module sdm_ctrl
  import sdm_ctrl_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned OSR     = 64,
  parameter int unsigned RST_CYC = 10,
  parameter int unsigned SAT_LIM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  input  logic [W-1:0]      s_data,
  output logic              s_ready,
  output logic              sdm_rstn,
  output logic [W-1:0]      sdm_din,
  input  logic [3:0]        sdm_out,
  output logic              sample_strobe,
  output logic              underrun,
  output logic [RCNT_W-1:0] restart_cnt,
  output logic [1:0]        state
);

  localparam int unsigned PH_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  logic [1:0]        state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [W-1:0]      buf_q, buf_d;
  logic              empty_q, empty_d;
  logic [W-1:0]      din_q, din_d;
  logic              rstn_q, rstn_d;
  logic              strobe_q, strobe_d;
  logic              under_q, under_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;

  logic in_run_c, sat_trip_c, slot_c, xfer_c, leave_run_c;

  sdm_sat_mon #(
    .SAT_LIM(SAT_LIM)
  ) u_sat_mon (
    .clk         (clk),
    .rst         (rst),
    .run_i       (in_run_c),
    .clr_i       (leave_run_c),
    .code_i      (sdm_out),
    .sat_trip_c_o(sat_trip_c)
  );

  // Next-state, buffer and slot logic.
  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    phase_d  = '0;
    buf_d    = buf_q;
    empty_d  = empty_q;
    din_d    = din_q;
    rstn_d   = 1'b0;
    strobe_d = 1'b0;
    under_d  = 1'b0;
    rcnt_d   = rcnt_q;

    in_run_c = en && (state_q == RUN);
    xfer_c   = s_valid && empty_q;
    // A tripping code takes priority over the slot so nothing moves into RECOVER.
    slot_c   = in_run_c && !sat_trip_c && (phase_q == '0);

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FLUSH;
          rc_d    = RC_W'(RST_CYC - 1);
        end
        FLUSH, RECOVER: begin
          if (rc_q == '0) begin
            state_d = RUN;
          end else begin
            rc_d = rc_q - RC_W'(1);
          end
        end
        RUN: begin
          if (sat_trip_c) begin
            state_d = RECOVER;
            rc_d    = RC_W'(RST_CYC - 1);
            if (rcnt_q != '1) begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
        end
      endcase
    end

    leave_run_c = (state_q == RUN) && (state_d != RUN);

    // Phase only advances while staying in RUN; any RUN entry starts at slot 0.
    if ((state_q == RUN) && (state_d == RUN)) begin
      phase_d = (phase_q == PH_W'(OSR - 1)) ? '0 : phase_q + PH_W'(1);
    end

    if (slot_c) begin
      if (!empty_q) begin
        din_d    = buf_q;
        empty_d  = 1'b1;
        strobe_d = 1'b1;
      end else begin
        under_d = 1'b1;
      end
    end

    // Only possible with an empty buffer, so never collides with a consume.
    if (xfer_c) begin
      buf_d   = s_data;
      empty_d = 1'b0;
    end

    rstn_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rc_q     <= '0;
      phase_q  <= '0;
      buf_q    <= '0;
      empty_q  <= 1'b1;
      din_q    <= '0;
      rstn_q   <= 1'b0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      phase_q  <= phase_d;
      buf_q    <= buf_d;
      empty_q  <= empty_d;
      din_q    <= din_d;
      rstn_q   <= rstn_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign s_ready       = empty_q;
  assign sdm_rstn      = rstn_q;
  assign sdm_din       = din_q;
  assign sample_strobe = strobe_q;
  assign underrun      = under_q;
  assign restart_cnt   = rcnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_sdm_ctrl.sv
// Bench for sdm_ctrl with OSR=4, RST_CYC=10, SAT_LIM=8.
module tb_sdm_ctrl;

  localparam int W       = 16;
  localparam int OSR     = 4;
  localparam int RST_CYC = 10;
  localparam int SAT_LIM = 8;

  logic         clk = 1'b0;
  logic         rst, en, s_valid;
  logic [W-1:0] s_data;
  logic [3:0]   sdm_out;
  logic         s_ready, sdm_rstn, sample_strobe, underrun;
  logic [W-1:0] sdm_din;
  logic [7:0]   restart_cnt;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  sdm_ctrl #(
    .W(W), .OSR(OSR), .RST_CYC(RST_CYC), .SAT_LIM(SAT_LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .sdm_rstn     (sdm_rstn),
    .sdm_din      (sdm_din),
    .sdm_out      (sdm_out),
    .sample_strobe(sample_strobe),
    .underrun     (underrun),
    .restart_cnt  (restart_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: states as plain ints, slots from cycles-since-RUN-entry.
  int         m_state, m_rem, m_age, m_streak, m_rcnt, nxt;
  bit         m_full, m_rstn, m_strobe, m_under, hs_q, xfer, sat;
  logic [W-1:0] m_buf, m_din;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_rem = 0; m_age = 0; m_streak = 0; m_rcnt = 0;
      m_full = 0; m_rstn = 0; m_strobe = 0; m_under = 0; hs_q = 0;
      m_buf = '0; m_din = '0;
    end else begin
      xfer = s_valid && !m_full;
      m_strobe = 0;
      m_under  = 0;
      nxt = m_state;
      if (!en) begin
        nxt = 0;
        if (m_state == 2) m_streak = 0;
      end else begin
        case (m_state)
          0: begin nxt = 1; m_rem = RST_CYC; end
          1, 3: begin
            m_rem--;
            if (m_rem == 0) begin nxt = 2; m_age = 0; end
          end
          default: begin
            sat = (sdm_out == 4'd7) || (sdm_out == 4'd8);
            m_streak = sat ? m_streak + 1 : 0;
            if (m_streak == SAT_LIM) begin
              nxt = 3; m_rem = RST_CYC; m_streak = 0;
              if (m_rcnt < 255) m_rcnt++;
            end else begin
              if (m_age % OSR == 0) begin
                if (m_full) begin m_din = m_buf; m_full = 0; m_strobe = 1; end
                else m_under = 1;
              end
              m_age++;
            end
          end
        endcase
      end
      if (xfer) begin m_full = 1; m_buf = s_data; end
      hs_q    = xfer;
      m_state = nxt;
      m_rstn  = (nxt == 2);
    end
    #2;
    chk("state",       int'(state),         m_state);
    chk("sdm_rstn",    int'(sdm_rstn),      int'(m_rstn));
    chk("sdm_din",     int'(sdm_din),       int'(m_din));
    chk("s_ready",     int'(s_ready),       int'(!m_full));
    chk("strobe",      int'(sample_strobe), int'(m_strobe));
    chk("underrun",    int'(underrun),      int'(m_under));
    chk("restart_cnt", int'(restart_cnt),   m_rcnt);
  end

  bit stream_on = 0;

  // Advance to the next falling edge; in streaming mode present the next value after each handshake.
  task automatic step();
    @(negedge clk);
    if (stream_on && hs_q) s_data = s_data + 16'd1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = '0; sdm_out = 4'd0;
    repeat (2) step();
    chk("rst_state",  int'(state),    0);
    chk("rst_sready", int'(s_ready),  1);
    chk("rst_rstn",   int'(sdm_rstn), 0);

    // Startup and streaming
    rst = 1'b0; s_valid = 1'b1; s_data = 16'd16385; stream_on = 1;
    step();
    chk("flush_first", int'(state), 1);
    repeat (9) step();
    chk("flush_last",  int'(state), 1);
    chk("flush_rstn",  int'(sdm_rstn), 0);
    step();
    chk("run_entry",   int'(state), 2);
    chk("run_rstn",    int'(sdm_rstn), 1);
    step();
    chk("slot0_strobe", int'(sample_strobe), 1);
    chk("slot0_din",    int'(sdm_din), 16385);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) step();
      chk("stream_strobe", int'(sample_strobe), 1);
      chk("stream_din",    int'(sdm_din), 16385 + k);
      chk("stream_under",  int'(underrun), 0);
    end

    // Starvation
    stream_on = 0; s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) step();
      chk("starve_under", int'(underrun), 1);
      chk("starve_din",   int'(sdm_din), 16389);
    end
    repeat (3) step();
    s_valid = 1'b1; s_data = 16'h1234;
    step();
    chk("slot_hs_under",  int'(underrun), 1);
    chk("slot_hs_sready", int'(s_ready), 0);
    s_valid = 1'b0;
    repeat (4) step();
    chk("late_strobe", int'(sample_strobe), 1);
    chk("late_din",    int'(sdm_din), 16'h1234);

    // Saturation: 7 codes, break, 8 codes
    sdm_out = 4'd7;
    repeat (7) step();
    sdm_out = 4'd0;
    step();
    chk("sat7_no_trip", int'(state), 2);
    sdm_out = 4'd7;
    repeat (7) step();
    chk("sat_pre_trip", int'(state), 2);
    step();
    chk("sat_trip_state", int'(state), 3);
    chk("sat_trip_rcnt",  int'(restart_cnt), 1);
    chk("sat_trip_rstn",  int'(sdm_rstn), 0);
    sdm_out = 4'd0;
    repeat (9) step();
    chk("recover_last", int'(state), 3);
    step();
    chk("recover_done", int'(state), 2);
    chk("recover_din",  int'(sdm_din), 16'h1234);

    // Alternating rails count as consecutive
    for (int i = 0; i < 8; i++) begin
      sdm_out = (i % 2 == 1) ? 4'd8 : 4'd7;
      step();
    end
    chk("alt_trip_state", int'(state), 3);
    chk("alt_trip_rcnt",  int'(restart_cnt), 2);
    sdm_out = 4'd0;
    repeat (10) step();
    chk("alt_recover", int'(state), 2);

    // Enable drop mid-RUN
    repeat (5) step();
    en = 1'b0;
    step();
    chk("en0_state", int'(state), 0);
    chk("en0_rstn",  int'(sdm_rstn), 0);
    chk("en0_din",   int'(sdm_din), 16'h1234);
    chk("en0_rcnt",  int'(restart_cnt), 2);
    en = 1'b1;
    step();
    chk("en1_flush", int'(state), 1);
    repeat (10) step();
    chk("en1_run", int'(state), 2);

    // Reset mid-RECOVER
    sdm_out = 4'd7;
    repeat (8) step();
    chk("trip3_state", int'(state), 3);
    chk("trip3_rcnt",  int'(restart_cnt), 3);
    sdm_out = 4'd0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_state",  int'(state), 0);
    chk("midrst_rstn",   int'(sdm_rstn), 0);
    chk("midrst_din",    int'(sdm_din), 0);
    chk("midrst_rcnt",   int'(restart_cnt), 0);
    chk("midrst_sready", int'(s_ready), 1);
    chk("midrst_strobe", int'(sample_strobe), 0);
    chk("midrst_under",  int'(underrun), 0);

    // Restart counter saturation under continuous rail codes
    rst = 1'b0; sdm_out = 4'd7;
    repeat (5600) step();
    chk("rcnt_sat", int'(restart_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
